hub75_scan: RTL and testbench
=============================

# hub75_scan

Read-side scan engine for the pixel RAM. It walks the 12-bit read port row by row and bit-plane by bit-plane, unpacks each 32-bit word into a top-half pixel and a bottom-half pixel, and drives a HUB75 panel with binary-coded modulation. It sits between the pixel RAM read port (1-cycle registered read latency) and the panel connector. The byte-wide writer fills the same RAM independently.

## Interface
- COL_BITS, 7: log2 of the panel column count. COLS = 2**COL_BITS.
- ROW_BITS, 5: log2 of the scan-row count, i.e. panel height / 2. Requires COL_BITS + ROW_BITS <= 12.
- BITS, 5: number of modulation bit-planes, range 1..5.
- BASE_TIME, 8: display cycles for plane 0. Plane b displays for BASE_TIME << b cycles. Must be >= 1.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows a new row/plane pass to start.
- read  out  1  pixel RAM read strobe.
- raddr  out  12  pixel RAM read address, {zero pad, row, col}.
- data_out  in  32  pixel RAM read data, valid the cycle after `read`.
- r0, g0, b0, r1, g1, b1  out  1 each  HUB75 colour bits (0 = top half, 1 = bottom half).
- clk_out  out  1  HUB75 shift clock. The panel samples on its rising edge.
- lat  out  1  HUB75 latch.
- oe_n  out  1  HUB75 output enable, active low.
- addr_out  out  ROW_BITS  HUB75 row address.
- frame_start  out  1  one-cycle pulse when the pass for row 0, plane 0 begins.

## Operation
- Word format: [31:16] is the top pixel {R5,G6,B5}; [15:0] is the bottom pixel {R5,G6,B5}.
- Plane b uses MSB-aligned bits:
  - R = R5[5-BITS+b]
  - G = G6[6-BITS+b]
  - B = B5[5-BITS+b]
- FSM states: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE → SHIFT when `enable` = 1. `frame_start` pulses on this transition if row = 0 and plane = 0.
- SHIFT: column counter c runs 0..COLS, two cycles per step.
  - Phase 0 (c < COLS): `read` = 1, `raddr` = {row, c}.
  - Phase 1: colour outputs are registered from `data_out`.
  - `clk_out` = 1 during phase 1 of step c+1. This clocks pixel c.
  - The extra step c = COLS issues no read and only clocks the last pixel.
  - SHIFT lasts 2·COLS + 2 cycles, then goes to LATCH.
- LATCH (1 cycle): `lat` = 1 and `addr_out` ← row, then go to DISPLAY.
- DISPLAY: `oe_n` = 0 for exactly BASE_TIME << plane cycles. Then:
  - plane increments.
  - When plane wraps past BITS-1, it returns to 0 and row increments, wrapping at 2**ROW_BITS.
  - Go to SHIFT if `enable` = 1, otherwise IDLE.
- `enable` is sampled only in IDLE and at the end of DISPLAY. Dropping it mid-pass completes the current plane.
- `oe_n` = 1 in every state other than DISPLAY. The row address and latch therefore change only while the panel is blanked.

## Timing
- Reset values: state IDLE, row = 0, plane = 0, all outputs 0 except `oe_n` = 1.
- Reset mid-operation returns immediately (asynchronously) to the reset values. The next pass restarts at row 0, plane 0.
- RAM latency: `data_out` is sampled exactly one cycle after `read`. `read` is never asserted on consecutive cycles.
- Colour bits are stable for 1 cycle before and 1 cycle after each `clk_out` rising edge.
- Cycles per plane pass: (2·COLS + 2) + 1 + (BASE_TIME << plane).
- Counters are sized so that BASE_TIME << (BITS-1) does not overflow: width = clog2(BASE_TIME) + BITS.

## Structure
- Shared package `hub75_pkg` holds:
  - the state enum;
  - field offsets of the top and bottom pixels and of R5/G6/B5;
  - the plane-bit extraction function.
- Sub-module `hub75_plane_timer` is the DISPLAY down-counter.
  - Inputs: load, plane.
  - Outputs: busy, done.
- The FSM, column/row/plane counters and output registers live in `hub75_scan`.

## Test plan
All scenarios use COL_BITS=2, ROW_BITS=1, BITS=2, BASE_TIME=4, with a 1-cycle RAM model.
- Reset then `enable` = 1:
  - `frame_start` pulses once.
  - Reads go to raddr 0,1,2,3 at cycles 0,2,4,6.
  - 4 `clk_out` pulses occur, then `lat` = 1 for 1 cycle, then `oe_n` = 0 for 4 cycles.
- Word 0xF800_07E0 at every address, plane 1:
  - r0 = 1, g0 = 0, b0 = 0.
  - r1 = 0, g1 = 1, b1 = 0.
- Full sequence:
  - Plane 1 displays 8 cycles.
  - Then row 1, plane 0, with `addr_out` = 1 latched.
  - After 4 passes, row wraps to 0 and `frame_start` pulses again.
- Drop `enable` mid-SHIFT: the pass completes through DISPLAY, then the FSM is IDLE with `oe_n` = 1 and `read` = 0.
- Assert `rst_n` = 0 mid-DISPLAY:
  - `oe_n` = 1 and all other outputs = 0 immediately.
  - On restart, the first raddr is 0.
- Protocol assertions, checked throughout:
  - `oe_n` = 0 never coincides with `lat` or `clk_out`.
  - `read` is never high 2 cycles in a row.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types, pixel field layout and bit-plane extraction for the HUB75 scan engine.
// Pure declarations: no state, no latency.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    // Plane index width covers the full 1..5 bit-plane range
    localparam int PLANE_W = 3;

    localparam int TOP_LSB = 16;
    localparam int BOT_LSB = 0;
    localparam int R_LSB   = 11;
    localparam int G_LSB   = 5;
    localparam int B_LSB   = 0;

    // Returns {R,G,B} for one plane; planes are MSB-aligned so BITS < 5 drops the LSBs
    function automatic logic [2:0] plane_rgb(input logic [15:0]        pix,
                                             input int                 bits,
                                             input logic [PLANE_W-1:0] plane);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        logic [2:0] ri;
        logic [2:0] gi;
        r5 = pix[R_LSB +: 5];
        g6 = pix[G_LSB +: 6];
        b5 = pix[B_LSB +: 5];
        ri = 3'(5 - bits + int'(plane));
        gi = 3'(6 - bits + int'(plane));
        return {r5[ri], g6[gi], b5[ri]};
    endfunction

endpackage

// File: rtl/hub75_plane_timer.sv
// DISPLAY down-counter: load sets BASE_TIME << plane, busy for exactly that many cycles.
// done marks the final busy cycle; no backpressure, a new load restarts the count.
module hub75_plane_timer
    import hub75_pkg::*;
#(
    parameter int BITS      = 5,
    parameter int BASE_TIME = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    output logic               busy,
    output logic               done
);

    localparam int TW = $clog2(BASE_TIME) + BITS;
    localparam logic [TW-1:0] BT = TW'(BASE_TIME);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= BT << plane;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == TW'(1));

endmodule

// File: rtl/hub75_scan.sv
// HUB75 scan engine: shifts one row/plane from pixel RAM, latches it, then lights it for BASE_TIME << plane.
// Pass length (2*COLS+2)+1+(BASE_TIME<<plane) cycles; enable gates only the start of each pass.
module hub75_scan
    import hub75_pkg::*;
#(
    parameter int COL_BITS  = 7,
    parameter int ROW_BITS  = 5,
    parameter int BITS      = 5,
    parameter int BASE_TIME = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                read,
    output logic [11:0]         raddr,
    input  logic [31:0]         data_out,
    output logic                r0,
    output logic                g0,
    output logic                b0,
    output logic                r1,
    output logic                g1,
    output logic                b1,
    output logic                clk_out,
    output logic                lat,
    output logic                oe_n,
    output logic [ROW_BITS-1:0] addr_out,
    output logic                frame_start
);

    localparam logic [COL_BITS:0] LAST_COL = {1'b1, {COL_BITS{1'b0}}};

    state_t               state;
    logic [COL_BITS:0]    col;
    logic                 phase;
    logic [ROW_BITS-1:0]  row;
    logic [PLANE_W-1:0]   plane;

    logic [COL_BITS:0]    col_nxt;
    logic                 last_plane;
    logic [PLANE_W-1:0]   next_plane;
    logic [ROW_BITS-1:0]  next_row;
    logic [2:0]           top_rgb;
    logic [2:0]           bot_rgb;

    logic                 tmr_load;
    logic                 tmr_busy;
    logic                 tmr_done;

    always_comb begin
        col_nxt    = col + 1'b1;
        last_plane = (plane == PLANE_W'(BITS - 1));
        next_plane = last_plane ? '0 : plane + 1'b1;
        next_row   = last_plane ? row + 1'b1 : row;
        top_rgb    = plane_rgb(data_out[TOP_LSB +: 16], BITS, plane);
        bot_rgb    = plane_rgb(data_out[BOT_LSB +: 16], BITS, plane);
    end

    assign tmr_load = (state == LATCH);

    hub75_plane_timer #(
        .BITS      (BITS),
        .BASE_TIME (BASE_TIME)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .plane (plane),
        .busy  (tmr_busy),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            phase       <= 1'b0;
            row         <= '0;
            plane       <= '0;
            read        <= 1'b0;
            raddr       <= '0;
            r0          <= 1'b0;
            g0          <= 1'b0;
            b0          <= 1'b0;
            r1          <= 1'b0;
            g1          <= 1'b0;
            b1          <= 1'b0;
            clk_out     <= 1'b0;
            lat         <= 1'b0;
            oe_n        <= 1'b1;
            addr_out    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= SHIFT;
                        col         <= '0;
                        phase       <= 1'b0;
                        read        <= 1'b1;
                        raddr       <= 12'({row, {COL_BITS{1'b0}}});
                        frame_start <= (row == '0) && (plane == '0);
                    end
                end

                SHIFT: begin
                    if (!phase) begin
                        // Rising shift clock for the pixel captured in the previous step
                        phase   <= 1'b1;
                        read    <= 1'b0;
                        clk_out <= (col != '0);
                    end else begin
                        clk_out <= 1'b0;
                        if (col != LAST_COL) begin
                            {r0, g0, b0} <= top_rgb;
                            {r1, g1, b1} <= bot_rgb;
                        end
                        if (col == LAST_COL) begin
                            state    <= LATCH;
                            lat      <= 1'b1;
                            addr_out <= row;
                        end else begin
                            col   <= col_nxt;
                            phase <= 1'b0;
                            read  <= (col_nxt != LAST_COL);
                            raddr <= 12'({row, col_nxt[COL_BITS-1:0]});
                        end
                    end
                end

                LATCH: begin
                    lat   <= 1'b0;
                    oe_n  <= 1'b0;
                    state <= DISPLAY;
                end

                DISPLAY: begin
                    // !busy guards against a lost load ever stranding the FSM here
                    if (tmr_done || !tmr_busy) begin
                        oe_n  <= 1'b1;
                        plane <= next_plane;
                        row   <= next_row;
                        if (enable) begin
                            state       <= SHIFT;
                            col         <= '0;
                            phase       <= 1'b0;
                            read        <= 1'b1;
                            raddr       <= 12'({next_row, {COL_BITS{1'b0}}});
                            frame_start <= (next_row == '0) && (next_plane == '0);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan.sv
// Directed bench for hub75_scan with a 1-cycle pixel RAM model and a hand-computed colour table.
module tb_hub75_scan;
    import hub75_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        read;
    logic [11:0] raddr;
    logic [31:0] data_out;
    logic        r0, g0, b0, r1, g1, b1;
    logic        clk_out;
    logic        lat;
    logic        oe_n;
    logic [0:0]  addr_out;
    logic        frame_start;

    hub75_scan #(
        .COL_BITS  (2),
        .ROW_BITS  (1),
        .BITS      (2),
        .BASE_TIME (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .read        (read),
        .raddr       (raddr),
        .data_out    (data_out),
        .r0          (r0),
        .g0          (g0),
        .b0          (b0),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .clk_out     (clk_out),
        .lat         (lat),
        .oe_n        (oe_n),
        .addr_out    (addr_out),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [31:0] word;
        logic [5:0]  p0;   // {r0,g0,b0,r1,g1,b1} expected on plane 0
        logic [5:0]  p1;   // same for plane 1
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] mem [8];
    int          total;
    int          passed;
    int          proto_err;
    logic        prev_read;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read) data_out <= mem[raddr[2:0]];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!oe_n && (lat || clk_out)) proto_err++;
            if (read && prev_read) proto_err++;
        end
        prev_read = read;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        else
            passed++;
    endtask

    function automatic logic [23:0] all_outs();
        return {read, raddr, r0, g0, b0, r1, g1, b1, clk_out, lat, oe_n, addr_out, frame_start};
    endfunction

    // Starts on the first SHIFT cycle of a pass and ends on the cycle after its DISPLAY
    task automatic run_pass(input int row, input int plane, input bit exp_fs, input int drop_at);
        int         disp;
        int         pix;
        logic [4:0] exp_ctl;
        logic [5:0] rgb;
        logic [5:0] prev_rgb;
        logic [5:0] exp_rgb;
        disp     = 4 << plane;
        prev_rgb = '0;
        for (int cyc = 0; cyc < 11 + disp; cyc++) begin
            rgb        = {r0, g0, b0, r1, g1, b1};
            exp_ctl[4] = (cyc < 8) && (cyc % 2 == 0);
            exp_ctl[3] = (cyc >= 3) && (cyc <= 9) && (cyc % 2 == 1);
            exp_ctl[2] = (cyc == 10);
            exp_ctl[1] = (cyc < 11);
            exp_ctl[0] = exp_fs && (cyc == 0);
            check($sformatf("ctl{read,clk_out,lat,oe_n,fs} r%0d p%0d c%0d", row, plane, cyc),
                  32'({read, clk_out, lat, oe_n, frame_start}), 32'(exp_ctl));
            if (exp_ctl[4])
                check($sformatf("raddr r%0d p%0d c%0d", row, plane, cyc),
                      32'(raddr), 32'(row * 4 + cyc / 2));
            if (exp_ctl[3]) begin
                pix     = row * 4 + (cyc - 3) / 2;
                exp_rgb = (plane != 0) ? tbl[pix].p1 : tbl[pix].p0;
                check($sformatf("rgb r%0d p%0d px%0d", row, plane, pix), 32'(rgb), 32'(exp_rgb));
                check($sformatf("rgb_setup r%0d p%0d px%0d", row, plane, pix), 32'(prev_rgb), 32'(exp_rgb));
            end
            if (exp_ctl[2])
                check($sformatf("addr_out r%0d p%0d", row, plane), 32'(addr_out), 32'(row));
            if (cyc == drop_at) enable = 1'b0;
            prev_rgb = rgb;
            tick();
        end
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        proto_err = 0;
        prev_read = 1'b0;
        tbl[0] = '{32'hF800_07E0, 6'b100_010, 6'b100_010};
        tbl[1] = '{32'h4000_0010, 6'b100_000, 6'b000_001};
        tbl[2] = '{32'h0200_0208, 6'b010_011, 6'b000_000};
        tbl[3] = '{32'h0418_8400, 6'b001_000, 6'b011_110};
        tbl[4] = '{32'hFFFF_FFFF, 6'b111_111, 6'b111_111};
        tbl[5] = '{32'h0000_0000, 6'b000_000, 6'b000_000};
        tbl[6] = '{32'h0008_4000, 6'b001_100, 6'b000_000};
        tbl[7] = '{32'h8000_0400, 6'b000_000, 6'b100_010};
        for (int i = 0; i < 8; i++) mem[i] = tbl[i].word;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        check("reset outputs", 32'(all_outs()), 32'(24'h000004));
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle hold without enable", 32'(all_outs()), 32'(24'h000004));

        // Four passes cover both rows and planes, the fifth shows the frame wrap
        enable = 1'b1;
        tick();
        run_pass(0, 0, 1'b1, -1);
        run_pass(0, 1, 1'b0, -1);
        run_pass(1, 0, 1'b0, -1);
        run_pass(1, 1, 1'b0, -1);
        run_pass(0, 0, 1'b1, -1);

        // Enable dropped mid-SHIFT: the pass still completes, then the FSM parks
        run_pass(0, 1, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("parked{read,oe_n,clk_out,lat} t%0d", i),
                  32'({read, oe_n, clk_out, lat}), 32'(4'b0100));
            tick();
        end

        enable = 1'b1;
        tick();
        run_pass(1, 0, 1'b0, -1);

        // Reset in the middle of plane-1 DISPLAY
        repeat (13) tick();
        check("oe_n low before reset", 32'(oe_n), 32'(0));
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'(all_outs()), 32'(24'h000004));
        rst_n = 1'b1;
        tick();
        run_pass(0, 0, 1'b1, -1);

        check("protocol violations", 32'(proto_err), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
